// File: rtl/mid_ctrl.sv
// LBIST mid-section controller: feeds TPG patterns to a faulty/fault-free CUT pair,
// compares masked outputs, drops detected faults and steps the FIL through the fault list.
module mid_ctrl #(
    parameter int IN_BITS  = 60,
    parameter int OUT_BITS = 26,
    parameter int MAX_PAT  = 1024,
    parameter int CUT_LAT  = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                TP_VALID,
    output logic                TP_READY,
    input  logic [IN_BITS-1:0]  TEST_IP,
    output logic [IN_BITS-1:0]  CUT_IP,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    input  logic [OUT_BITS-1:0] OUT_MASK,
    output logic                FIL_INC,
    input  logic                FIL_END,
    output logic                BUSY,
    output logic                DONE,
    output logic                DET_PULSE,
    output logic [CNT_W-1:0]    FAULT_CNT,
    output logic [CNT_W-1:0]    DET_CNT
);

    localparam int PAT_W = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;
    localparam int LAT_W = (CUT_LAT > 0) ? $clog2(CUT_LAT + 1) : 1;
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(MAX_PAT - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(CUT_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CMP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [PAT_W-1:0]    pat_reg, pat_next;
    logic [LAT_W-1:0]    lat_reg, lat_next;
    logic [IN_BITS-1:0]  cut_ip_reg, cut_ip_next;
    logic [CNT_W-1:0]    fault_cnt_reg, fault_cnt_next;
    logic [CNT_W-1:0]    det_cnt_reg, det_cnt_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                det_pulse_reg, det_pulse_next;
    logic                fil_inc_reg, fil_inc_next;

    // Per-bit masked difference; masked-off bits may carry X from the CUTs.
    logic [OUT_BITS-1:0] diff_bits;
    logic                miss;

    generate
        for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_cmp
            assign diff_bits[gi] = (CUT_OP[gi] ^ FF_OP[gi]) & OUT_MASK[gi];
        end
    endgenerate

    assign miss = |diff_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pat_reg       <= '0;
            lat_reg       <= '0;
            cut_ip_reg    <= '0;
            fault_cnt_reg <= '0;
            det_cnt_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            det_pulse_reg <= 1'b0;
            fil_inc_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pat_reg       <= pat_next;
            lat_reg       <= lat_next;
            cut_ip_reg    <= cut_ip_next;
            fault_cnt_reg <= fault_cnt_next;
            det_cnt_reg   <= det_cnt_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            det_pulse_reg <= det_pulse_next;
            fil_inc_reg   <= fil_inc_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pat_next       = pat_reg;
        lat_next       = lat_reg;
        cut_ip_next    = cut_ip_reg;
        fault_cnt_next = fault_cnt_reg;
        det_cnt_next   = det_cnt_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        det_pulse_next = 1'b0;
        fil_inc_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_APPLY;
                    busy_next  = 1'b1;
                    pat_next   = '0;
                end
            end
            S_APPLY: begin
                if (TP_VALID) begin
                    cut_ip_next = TEST_IP;
                    lat_next    = LAT_INIT;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_reg == '0) begin
                    state_next = S_CMP;
                end else begin
                    lat_next = lat_reg - 1'b1;
                end
            end
            S_CMP: begin
                // A detection on the final budgeted pattern still counts as detected.
                if (miss) begin
                    det_pulse_next = 1'b1;
                    det_cnt_next   = sat_inc(det_cnt_reg);
                    fault_cnt_next = sat_inc(fault_cnt_reg);
                    state_next     = S_NEXT;
                end else if (pat_reg == PAT_LAST) begin
                    fault_cnt_next = sat_inc(fault_cnt_reg);
                    state_next     = S_NEXT;
                end else begin
                    pat_next   = pat_reg + 1'b1;
                    state_next = S_APPLY;
                end
            end
            S_NEXT: begin
                if (FIL_END) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    fil_inc_next = 1'b1;
                    pat_next     = '0;
                    state_next   = S_APPLY;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign TP_READY  = (state_reg == S_APPLY);
    assign CUT_IP    = cut_ip_reg;
    assign FIL_INC   = fil_inc_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;
    assign DET_PULSE = det_pulse_reg;
    assign FAULT_CNT = fault_cnt_reg;
    assign DET_CNT   = det_cnt_reg;

endmodule

// File: tb/tb_mid_ctrl.sv
// Bench for mid_ctrl: timestamp-based reference model of the fault campaign, a per-cycle
// output compare, and directed plus randomized campaigns against an emulated FIL and CUT pair.
module tb_mid_ctrl;

    localparam int IN_BITS  = 60;
    localparam int OUT_BITS = 26;
    localparam int MAX_PAT  = 4;
    localparam int CUT_LAT  = 2;
    localparam int CNT_W    = 3;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                TP_VALID = 1'b0;
    logic                TP_READY;
    logic [IN_BITS-1:0]  TEST_IP = '0;
    logic [IN_BITS-1:0]  CUT_IP;
    logic [OUT_BITS-1:0] CUT_OP = '0;
    logic [OUT_BITS-1:0] FF_OP = '0;
    logic [OUT_BITS-1:0] OUT_MASK = '0;
    logic                FIL_INC;
    logic                FIL_END;
    logic                BUSY;
    logic                DONE;
    logic                DET_PULSE;
    logic [CNT_W-1:0]    FAULT_CNT;
    logic [CNT_W-1:0]    DET_CNT;

    always #5 clk = ~clk;

    mid_ctrl #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS),
        .MAX_PAT (MAX_PAT),
        .CUT_LAT (CUT_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .TP_VALID (TP_VALID),
        .TP_READY (TP_READY),
        .TEST_IP  (TEST_IP),
        .CUT_IP   (CUT_IP),
        .CUT_OP   (CUT_OP),
        .FF_OP    (FF_OP),
        .OUT_MASK (OUT_MASK),
        .FIL_INC  (FIL_INC),
        .FIL_END  (FIL_END),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DET_PULSE(DET_PULSE),
        .FAULT_CNT(FAULT_CNT),
        .DET_CNT  (DET_CNT)
    );

    int errors = 0;
    int checks = 0;
    int fail_prints = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // Environment: FIL position and fault-list length, detection plan for directed runs.
    int                  nfaults = 1;
    int                  fil_idx = 0;
    int                  det_pat[16];
    logic [OUT_BITS-1:0] dir_mask = '1;
    logic [3:0]          vseq = 4'b1001;
    int                  vidx = 0;

    assign FIL_END = (fil_idx == nfaults - 1);

    // Reference model, expressed as event timestamps: an accepted pattern is judged at
    // edge accept+2+CUT_LAT, and a finished fault is resolved one edge later.
    int                  m_n = 0;
    int                  cmp_at = -1;
    int                  resolve_at = -1;
    int                  m_pats = 0;
    bit                  m_idle = 1'b1;
    bit                  m_wait_pat = 1'b0;
    bit                  m_busy = 1'b0;
    bit                  m_done = 1'b0;
    bit                  m_pulse = 1'b0;
    bit                  m_inc = 1'b0;
    int                  m_fault = 0;
    int                  m_det = 0;
    logic [IN_BITS-1:0]  m_ip = '0;
    bit                  inc_was;
    bit                  m_miss;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_n = 0; cmp_at = -1; resolve_at = -1; m_pats = 0;
            m_idle = 1'b1; m_wait_pat = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_pulse = 1'b0; m_inc = 1'b0; m_fault = 0; m_det = 0; m_ip = '0;
            fil_idx = 0;
        end else begin
            m_n++;
            inc_was = m_inc;
            m_pulse = 1'b0;
            m_inc   = 1'b0;
            if (m_idle && start) begin
                m_idle = 1'b0; m_wait_pat = 1'b1; m_busy = 1'b1; m_pats = 0;
            end else if (m_wait_pat && TP_VALID) begin
                m_wait_pat = 1'b0;
                m_ip       = TEST_IP;
                cmp_at     = m_n + 2 + CUT_LAT;
            end
            if (m_n == cmp_at) begin
                m_miss = |((CUT_OP ^ FF_OP) & OUT_MASK);
                if (m_miss) begin
                    m_det   = (m_det < CMAX) ? m_det + 1 : CMAX;
                    m_fault = (m_fault < CMAX) ? m_fault + 1 : CMAX;
                    m_pulse = 1'b1;
                    resolve_at = m_n + 1;
                end else if (m_pats == MAX_PAT - 1) begin
                    m_fault = (m_fault < CMAX) ? m_fault + 1 : CMAX;
                    resolve_at = m_n + 1;
                end else begin
                    m_pats++;
                    m_wait_pat = 1'b1;
                end
            end
            if (m_n == resolve_at) begin
                if (fil_idx == nfaults - 1) begin
                    m_done = 1'b1; m_busy = 1'b0;
                end else begin
                    m_inc = 1'b1; m_pats = 0; m_wait_pat = 1'b1;
                end
            end
            if (inc_was) fil_idx++;
        end
    end

    // Per-cycle compare, plus counts of observed handshakes and FIL steps.
    int acc_cnt = 0;
    int inc_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            acc_cnt = 0;
            inc_cnt = 0;
        end else begin
            if (TP_VALID && TP_READY) acc_cnt++;
            if (FIL_INC) inc_cnt++;
        end
        chk("tp_ready", TP_READY, m_wait_pat);
        chk("busy", BUSY, m_busy);
        chk("done", DONE, m_done);
        chk("det_pulse", DET_PULSE, m_pulse);
        chk("fil_inc", FIL_INC, m_inc);
        chk("fault_cnt", FAULT_CNT, m_fault);
        chk("det_cnt", DET_CNT, m_det);
        chk("cut_ip", CUT_IP, m_ip);
    end

    // CUT emulation: outputs are only meaningful in the judged cycle; every other cycle
    // carries unmasked garbage so a mistimed compare shows up as a spurious detection.
    task automatic drive(input bit rnd);
        logic [OUT_BITS-1:0] ff, diff, mask;
        ff = OUT_BITS'($urandom);
        if (cmp_at == m_n + 1) begin
            if (rnd) begin
                diff = ($urandom_range(0, 3) == 0) ?
                       (OUT_BITS'(1) << $urandom_range(0, OUT_BITS - 1)) : '0;
                mask = OUT_BITS'($urandom);
            end else begin
                diff = (det_pat[fil_idx] == m_pats) ? (OUT_BITS'(1) << 5) : '0;
                mask = dir_mask;
            end
        end else begin
            diff = OUT_BITS'($urandom) | OUT_BITS'(1);
            mask = '1;
        end
        FF_OP    = ff;
        CUT_OP   = ff ^ diff;
        OUT_MASK = mask;
        TEST_IP  = IN_BITS'({$urandom, $urandom});
        TP_VALID = rnd ? 1'($urandom_range(0, 1)) : vseq[vidx % 4];
        vidx++;
    endtask

    task automatic step(input bit rnd);
        drive(rnd);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int nf);
        rst = 1'b1; start = 1'b0; TP_VALID = 1'b0; nfaults = nf; vidx = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic plan(input int p0, input int p1, input int p2, input logic [OUT_BITS-1:0] mask);
        for (int i = 0; i < 16; i++) det_pat[i] = -1;
        det_pat[0] = p0; det_pat[1] = p1; det_pat[2] = p2;
        dir_mask = mask;
    endtask

    task automatic run(input int nf, input bit rnd);
        do_reset(nf);
        start = 1'b1;
        step(rnd);
        start = 1'b0;
        for (int c = 0; c < 3000 && !m_done; c++) step(rnd);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // 1: asynchronous reset while a pattern is in flight for fault 1
        plan(0, -1, -1, '1);
        do_reset(3);
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (m_fault == 1 && cmp_at > m_n) break;
            step(1'b0);
        end
        chk("t1_pre_fault_cnt", FAULT_CNT, 1);
        chk("t1_pre_busy", BUSY, 1);
        rst = 1'b1;
        #1;
        chk("t1_busy", BUSY, 0);
        chk("t1_done", DONE, 0);
        chk("t1_fault_cnt", FAULT_CNT, 0);
        chk("t1_det_cnt", DET_CNT, 0);
        chk("t1_cut_ip", CUT_IP, 0);
        chk("t1_tp_ready", TP_READY, 0);
        $display("t1 reset mid-wait: busy=%0d fault_cnt=%0d", BUSY, FAULT_CNT);

        // 2: detection on pattern 2 of fault 0, fault 1 runs out its budget
        plan(2, -1, -1, '1);
        run(2, 1'b0);
        chk("t2_fault_cnt", FAULT_CNT, 2);
        chk("t2_det_cnt", DET_CNT, 1);
        chk("t2_fil_inc", inc_cnt, 1);
        chk("t2_accepted", acc_cnt, 7);
        chk("t2_done", DONE, 1);
        $display("t2 detect: fault_cnt=%0d det_cnt=%0d acc=%0d", FAULT_CNT, DET_CNT, acc_cnt);

        // 3: budget exhaustion on the only fault
        plan(-1, -1, -1, '1);
        run(1, 1'b0);
        chk("t3_accepted", acc_cnt, 4);
        chk("t3_fault_cnt", FAULT_CNT, 1);
        chk("t3_det_cnt", DET_CNT, 0);
        chk("t3_fil_inc", inc_cnt, 0);
        chk("t3_done", DONE, 1);
        $display("t3 budget: fault_cnt=%0d acc=%0d", FAULT_CNT, acc_cnt);

        // 5: mismatch on bit 5 masked off, then compared
        plan(0, -1, -1, ~(OUT_BITS'(1) << 5));
        run(1, 1'b0);
        chk("t5a_det_cnt", DET_CNT, 0);
        chk("t5a_accepted", acc_cnt, 4);
        plan(0, -1, -1, '1);
        run(1, 1'b0);
        chk("t5b_det_cnt", DET_CNT, 1);
        chk("t5b_accepted", acc_cnt, 1);
        $display("t5 mask: det_cnt=%0d acc=%0d", DET_CNT, acc_cnt);

        // 6: three-fault campaign, detect faults 0 and 2 (fault 2 on its last pattern)
        plan(1, -1, 3, '1);
        run(3, 1'b0);
        chk("t6_fault_cnt", FAULT_CNT, 3);
        chk("t6_det_cnt", DET_CNT, 2);
        chk("t6_fil_inc", inc_cnt, 2);
        chk("t6_accepted", acc_cnt, 10);
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        for (int c = 0; c < 10; c++) step(1'b0);
        chk("t6_done_held", DONE, 1);
        chk("t6_busy_after_start", BUSY, 0);
        chk("t6_fault_cnt_frozen", FAULT_CNT, 3);
        $display("t6 campaign: fault_cnt=%0d det_cnt=%0d fil_inc=%0d", FAULT_CNT, DET_CNT, inc_cnt);

        // Saturation: ten immediately detected faults against 3-bit counters
        plan(0, 0, 0, '1);
        for (int i = 3; i < 16; i++) det_pat[i] = 0;
        run(10, 1'b0);
        chk("sat_fault_cnt", FAULT_CNT, 7);
        chk("sat_det_cnt", DET_CNT, 7);
        chk("sat_fil_inc", inc_cnt, 9);
        chk("sat_accepted", acc_cnt, 10);
        $display("sat: fault_cnt=%0d det_cnt=%0d", FAULT_CNT, DET_CNT);

        // Randomized campaigns checked cycle by cycle against the model
        for (int r = 0; r < 8; r++) begin
            run($urandom_range(1, 5), 1'b1);
            chk("rnd_done", DONE, 1);
            $display("rnd %0d: faults=%0d fault_cnt=%0d det_cnt=%0d acc=%0d",
                     r, nfaults, FAULT_CNT, DET_CNT, acc_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
